dlsc_dcm_prog_rx: RTL and testbench

//  Responder for the DCM_CLKGEN serial M/D programming port (PROGEN/PROGDATA/PROGDONE).

---
 rtl/dlsc_dcm_prog_rx_pkg.sv | 36 +++
 rtl/dlsc_dcm_prog_rx_if.sv | 21 ++
 rtl/dlsc_dcm_prog_lockcnt.sv | 32 +++
 rtl/dlsc_dcm_prog_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_dlsc_dcm_prog_rx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlsc_dcm_prog_rx_pkg.sv
// Shared constants, state encoding and the Go validity rule for the
// DCM_CLKGEN programming-port responder.
package dlsc_dcm_prog_rx_pkg;

    // Frame opcode bits
    localparam logic OP_LOAD    = 1'b1;
    localparam logic SEL_D      = 1'b0;
    localparam logic SEL_M      = 1'b1;
    localparam int   FRAME_BITS = 10;

    // Lock counter width; covers any practical LOCK_CYCLES value
    localparam int   LOCK_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRST    = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_LOCKWAIT = 3'd4
    } state_t;

    // A Go is accepted when M >= 2 and M <= md_max * D, all in 16-bit
    // unsigned arithmetic. Inputs are the stored M-1 / D-1 values.
    function automatic logic go_valid(input logic [7:0]  m_minus1,
                                      input logic [7:0]  d_minus1,
                                      input logic [15:0] md_max);
        logic [15:0] m_val;
        logic [15:0] d_val;
        logic [15:0] limit;
        m_val = {8'd0, m_minus1} + 16'd1;
        d_val = {8'd0, d_minus1} + 16'd1;
        limit = md_max * d_val;
        return (m_minus1 != 8'd0) && (m_val <= limit);
    endfunction

endpackage

// File: rtl/dlsc_dcm_prog_rx_if.sv
// Serial programming port bundle (PROGEN / PROGDATA / PROGDONE).
// The controller side is the master; the DCM responder is the slave.
interface dlsc_dcm_prog_rx_if;

    logic prog_en;
    logic prog_data;
    logic prog_done;

    modport master (
        output prog_en,
        output prog_data,
        input  prog_done
    );

    modport slave (
        input  prog_en,
        input  prog_data,
        output prog_done
    );

endinterface

// File: rtl/dlsc_dcm_prog_lockcnt.sv
// Loadable down-counter with a terminal strobe when the count reaches 1.
// Resets to RESET_VAL so the lock wait starts straight out of reset.
module dlsc_dcm_prog_lockcnt #(
    parameter int WIDTH     = 16,
    parameter int RESET_VAL = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             term
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count;

    // Count register: load has priority, decrement saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= WIDTH'(RESET_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign term = (count == ONE);

endmodule

// File: rtl/dlsc_dcm_prog_rx.sv
// DCM_CLKGEN programming-port responder: deserializes LoadD/LoadM/Go frames,
// keeps pending and active M-1/D-1 values and emulates PROGDONE/LOCKED timing.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_IDLE     | waiting for a frame to start
//  ST_FIRST    | bit0 captured; decide load / Go / framing error
//  ST_SHIFT    | load frame, shifting value bits 2..9
//  ST_DRAIN    | frame body done or broken; wait for prog_en to drop
//  ST_LOCKWAIT | counting down to lock after reset or an accepted Go
module dlsc_dcm_prog_rx
    import dlsc_dcm_prog_rx_pkg::*;
#(
    parameter int CLK_MULTIPLY = 4,
    parameter int CLK_DIVIDE   = 1,
    parameter int MD_MAX       = 4,
    parameter int LOCK_CYCLES  = 64
) (
    input  logic                clk,
    input  logic                rst,
    dlsc_dcm_prog_rx_if.slave   prog,
    input  logic                err_clear,
    output logic                locked,
    output logic [7:0]          mult,
    output logic [7:0]          div,
    output logic                cfg_update,
    output logic [1:0]          err
);

    localparam logic [7:0] MULT_RST = 8'(CLK_MULTIPLY - 1);
    localparam logic [7:0] DIV_RST  = 8'(CLK_DIVIDE - 1);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    state_t     state;
    state_t     state_nx;

    logic       first_bit;
    logic       sel;
    logic [3:0] bit_idx;
    logic [7:0] shreg;
    logic [7:0] shift_val;
    logic [7:0] pend_m;
    logic [7:0] pend_d;

    logic       cap_first;
    logic       cap_sel;
    logic       shift_en;
    logic       wr_pend;
    logic       go_ok;
    logic       go_bad;
    logic       done_set;
    logic       done_clr;
    logic       frm_err;
    logic       lock_set;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_term;

    // Value bits arrive LSB first; bit 9 completes the byte on the same edge
    assign shift_val = {prog.prog_data, shreg[7:1]};

    dlsc_dcm_prog_lockcnt #(
        .WIDTH     (LOCK_CNT_W),
        .RESET_VAL (LOCK_CYCLES)
    ) u_lockcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOCK_CNT_W'(LOCK_CYCLES)),
        .dec      (cnt_dec),
        .term     (cnt_term)
    );

    // State register; reset starts a lock wait as a real DCM would
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOCKWAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nx  = state;
        cap_first = 1'b0;
        cap_sel   = 1'b0;
        shift_en  = 1'b0;
        wr_pend   = 1'b0;
        go_ok     = 1'b0;
        go_bad    = 1'b0;
        done_set  = 1'b0;
        done_clr  = 1'b0;
        frm_err   = 1'b0;
        lock_set  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prog.prog_en) begin
                    cap_first = 1'b1;
                    done_clr  = 1'b1;
                    state_nx  = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (prog.prog_en) begin
                    if (first_bit == OP_LOAD) begin
                        cap_sel  = 1'b1;
                        state_nx = ST_SHIFT;
                    end else begin
                        // a Go must be exactly one cycle long
                        frm_err  = 1'b1;
                        state_nx = ST_DRAIN;
                    end
                end else if (first_bit == OP_LOAD) begin
                    frm_err  = 1'b1;
                    done_set = 1'b1;
                    state_nx = ST_IDLE;
                end else if (go_valid(pend_m, pend_d, 16'(MD_MAX))) begin
                    go_ok    = 1'b1;
                    cnt_load = 1'b1;
                    state_nx = ST_LOCKWAIT;
                end else begin
                    go_bad   = 1'b1;
                    done_set = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (prog.prog_en) begin
                    shift_en = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        wr_pend  = 1'b1;
                        state_nx = ST_DRAIN;
                    end
                end else begin
                    // short frame: discard the partial value
                    frm_err  = 1'b1;
                    done_set = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (prog.prog_en) begin
                    frm_err = 1'b1;
                end else begin
                    done_set = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_LOCKWAIT: begin
                cnt_dec = 1'b1;
                if (prog.prog_en) begin
                    frm_err = 1'b1;
                end
                if (cnt_term) begin
                    lock_set = 1'b1;
                    done_set = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Frame deserializer: opcode bits, bit index and value shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_bit <= 1'b0;
            sel       <= SEL_D;
            bit_idx   <= 4'd0;
            shreg     <= 8'd0;
        end else begin
            if (cap_first) begin
                first_bit <= prog.prog_data;
            end
            if (cap_sel) begin
                sel     <= prog.prog_data;
                bit_idx <= 4'd2;
            end
            if (shift_en) begin
                shreg   <= shift_val;
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

    // Pending values written by complete load frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_m <= MULT_RST;
            pend_d <= DIV_RST;
        end else if (wr_pend) begin
            if (sel == SEL_M) begin
                pend_m <= shift_val;
            end else begin
                pend_d <= shift_val;
            end
        end
    end

    // Active configuration and its one-cycle change strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult       <= MULT_RST;
            div        <= DIV_RST;
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= go_ok;
            if (go_ok) begin
                mult <= pend_m;
                div  <= pend_d;
            end
        end
    end

    // PROGDONE and LOCKED emulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog.prog_done <= 1'b0;
            locked         <= 1'b0;
        end else begin
            if (done_set) begin
                prog.prog_done <= 1'b1;
            end else if (done_clr) begin
                prog.prog_done <= 1'b0;
            end
            if (lock_set) begin
                locked <= 1'b1;
            end else if (go_ok) begin
                locked <= 1'b0;
            end
        end
    end

    // Sticky error bits; a new error in the clear cycle keeps its bit set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 2'b00;
        end else begin
            err <= (err & ~{2{err_clear}}) | {go_bad, frm_err};
        end
    end

endmodule

// File: tb/tb_dlsc_dcm_prog_rx.sv
// Self-checking bench for dlsc_dcm_prog_rx. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Accepted Go commands push the
// expected {mult,div} into a queue that a monitor pops on each cfg_update.
module tb_dlsc_dcm_prog_rx;
    import dlsc_dcm_prog_rx_pkg::*;

    localparam int CLK_MULTIPLY = 4;
    localparam int CLK_DIVIDE   = 1;
    localparam int MD_MAX       = 4;
    localparam int LOCK_CYCLES  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clear = 1'b0;
    logic       locked;
    logic [7:0] mult;
    logic [7:0] div;
    logic       cfg_update;
    logic [1:0] err;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    // bench model of pending and active M-1 / D-1
    int pm, pd, am, ad;

    dlsc_dcm_prog_rx_if pif ();

    dlsc_dcm_prog_rx #(
        .CLK_MULTIPLY (CLK_MULTIPLY),
        .CLK_DIVIDE   (CLK_DIVIDE),
        .MD_MAX       (MD_MAX),
        .LOCK_CYCLES  (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .prog       (pif.slave),
        .err_clear  (err_clear),
        .locked     (locked),
        .mult       (mult),
        .div        (div),
        .cfg_update (cfg_update),
        .err        (err)
    );

    always #5 clk = ~clk;

    // scoreboard monitor: every cfg_update strobe must match the next expected config
    always @(negedge clk) begin
        if (!rst && cfg_update === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL cfg_update_unexpected: got strobe with mult=%0d div=%0d, want no strobe", mult, div);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mult, div} !== mon_exp) begin
                    n_err++;
                    $display("FAIL cfg_update_value: got mult=%0d div=%0d, want mult=%0d div=%0d",
                             mult, div, mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
        $fatal(1, "timeout");
    end

    function automatic bit model_go_valid();
        return (pm >= 1) && ((pm + 1) <= MD_MAX * (pd + 1));
    endfunction

    task automatic model_reset();
        pm = CLK_MULTIPLY - 1;
        pd = CLK_DIVIDE - 1;
        am = pm;
        ad = pd;
        exp_q.delete();
    endtask

    // counts falling edges from now until locked, bounded
    task automatic wait_lock(output int cnt);
        cnt = 0;
        while (locked !== 1'b1 && cnt < 4 * LOCK_CYCLES) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic reset_dut();
        int cnt;
        @(negedge clk);
        rst = 1'b1;
        pif.prog_en = 1'b0;
        pif.prog_data = 1'b0;
        err_clear = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_lock(cnt);
    endtask

    // n high cycles carrying bits[0..n-1], then one low cycle driven
    task automatic drive_frame(input int n, input logic [15:0] bits);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pif.prog_en = 1'b1;
            pif.prog_data = bits[i];
        end
        @(negedge clk);
        pif.prog_en = 1'b0;
        pif.prog_data = 1'b0;
    endtask

    task automatic pulse_err_clear();
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_vec++;
        if (err !== 2'b00) begin
            n_err++;
            $display("FAIL err_clear: got err=%b, want 00", err);
        end
    endtask

    task automatic send_load(input logic s, input logic [7:0] val);
        drive_frame(FRAME_BITS, 16'({val, s, OP_LOAD}));
        n_vec++;
        if (pif.prog_done !== 1'b0) begin
            n_err++;
            $display("FAIL load_done_low: got prog_done=%b, want 0", pif.prog_done);
        end
        @(negedge clk);
        n_vec++;
        if (pif.prog_done !== 1'b1) begin
            n_err++;
            $display("FAIL load_done_high: got prog_done=%b, want 1", pif.prog_done);
        end
        if (s == SEL_M) pm = int'(val);
        else            pd = int'(val);
    endtask

    task automatic do_go(input string tag);
        bit valid;
        int cnt;
        valid = model_go_valid();
        if (valid) begin
            exp_q.push_back({8'(pm), 8'(pd)});
            am = pm;
            ad = pd;
        end
        drive_frame(1, 16'h0000);
        n_vec++;
        if (pif.prog_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s go_done_low: got prog_done=%b, want 0", tag, pif.prog_done);
        end
        @(negedge clk);
        if (valid) begin
            n_vec++;
            if (locked !== 1'b0 || pif.prog_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s go_unlock: got locked=%b prog_done=%b, want 0 0", tag, locked, pif.prog_done);
            end
            wait_lock(cnt);
            n_vec++;
            if (cnt != LOCK_CYCLES) begin
                n_err++;
                $display("FAIL %s go_lock_time: got %0d cycles, want %0d", tag, cnt, LOCK_CYCLES);
            end
            n_vec++;
            if (pif.prog_done !== 1'b1) begin
                n_err++;
                $display("FAIL %s go_done_high: got prog_done=%b, want 1", tag, pif.prog_done);
            end
            n_vec++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL %s cfg_update_missing: got %0d pending, want 0", tag, exp_q.size());
            end
        end else begin
            n_vec++;
            if (err[1] !== 1'b1 || pif.prog_done !== 1'b1) begin
                n_err++;
                $display("FAIL %s go_reject: got err=%b prog_done=%b, want err[1]=1 prog_done=1", tag, err, pif.prog_done);
            end
        end
        n_vec++;
        if (mult !== 8'(am) || div !== 8'(ad)) begin
            n_err++;
            $display("FAIL %s go_active: got mult=%0d div=%0d, want mult=%0d div=%0d", tag, mult, div, am, ad);
        end
    endtask

    task automatic test_reset();
        int cnt;
        pif.prog_en = 1'b0;
        pif.prog_data = 1'b0;
        model_reset();
        @(negedge clk);
        n_vec++;
        if (pif.prog_done !== 1'b0 || locked !== 1'b0 || cfg_update !== 1'b0 || err !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags: got done=%b locked=%b upd=%b err=%b, want 0 0 0 00",
                     pif.prog_done, locked, cfg_update, err);
        end
        n_vec++;
        if (mult !== 8'd3 || div !== 8'd0) begin
            n_err++;
            $display("FAIL reset_md: got mult=%0d div=%0d, want 3 0", mult, div);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_lock(cnt);
        n_vec++;
        if (cnt != LOCK_CYCLES) begin
            n_err++;
            $display("FAIL reset_lock_time: got %0d cycles, want %0d", cnt, LOCK_CYCLES);
        end
        n_vec++;
        if (pif.prog_done !== 1'b1 || mult !== 8'd3 || div !== 8'd0) begin
            n_err++;
            $display("FAIL reset_after_lock: got done=%b mult=%0d div=%0d, want 1 3 0", pif.prog_done, mult, div);
        end
    endtask

    task automatic test_load_go();
        send_load(SEL_D, 8'h01);
        send_load(SEL_M, 8'h04);
        do_go("load_go");
        n_vec++;
        if (mult !== 8'd4 || div !== 8'd1 || err !== 2'b00 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL load_go_result: got mult=%0d div=%0d err=%b locked=%b, want 4 1 00 1", mult, div, err, locked);
        end
    endtask

    task automatic test_framing();
        // short load frame: 6 high cycles
        drive_frame(6, 16'h03FF);
        n_vec++;
        if (pif.prog_done !== 1'b0) begin
            n_err++;
            $display("FAIL short_done_low: got prog_done=%b, want 0", pif.prog_done);
        end
        @(negedge clk);
        n_vec++;
        if (err !== 2'b01 || pif.prog_done !== 1'b1) begin
            n_err++;
            $display("FAIL short_frame: got err=%b prog_done=%b, want 01 1", err, pif.prog_done);
        end
        pulse_err_clear();
        // two-cycle frame with bit0=0
        drive_frame(2, 16'h0000);
        @(negedge clk);
        n_vec++;
        if (err !== 2'b01 || pif.prog_done !== 1'b1) begin
            n_err++;
            $display("FAIL long_go: got err=%b prog_done=%b, want 01 1", err, pif.prog_done);
        end
        pulse_err_clear();
        // pending must be untouched by the broken frames
        do_go("after_short");
        // 12-cycle LoadD 0x02: overrun flagged, value still written
        drive_frame(12, 16'({8'h02, SEL_D, OP_LOAD}));
        @(negedge clk);
        pd = 2;
        n_vec++;
        if (err !== 2'b01 || pif.prog_done !== 1'b1) begin
            n_err++;
            $display("FAIL overrun: got err=%b prog_done=%b, want 01 1", err, pif.prog_done);
        end
        pulse_err_clear();
        do_go("after_overrun");
    endtask

    task automatic test_invalid();
        int cnt;
        reset_dut();
        send_load(SEL_M, 8'h0F);
        do_go("m_too_big");
        cnt = 0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (mult !== 8'd3 || locked !== 1'b1 || err !== 2'b10) begin
            n_err++;
            $display("FAIL invalid_hold: got mult=%0d locked=%b err=%b, want 3 1 10", mult, locked, err);
        end
        pulse_err_clear();
        send_load(SEL_M, 8'h00);
        do_go("m_zero");
        pulse_err_clear();
    endtask

    task automatic test_back_to_back();
        int cnt;
        send_load(SEL_D, 8'h02);
        send_load(SEL_D, 8'h00);
        send_load(SEL_M, 8'h03);
        // M == MD_MAX*D exactly: accepted
        exp_q.push_back({8'(pm), 8'(pd)});
        am = pm;
        ad = pd;
        drive_frame(1, 16'h0000);
        @(negedge clk);
        // prog_en during the lock wait, together with err_clear: set wins
        pif.prog_en = 1'b1;
        err_clear = 1'b1;
        @(negedge clk);
        pif.prog_en = 1'b0;
        err_clear = 1'b0;
        n_vec++;
        if (err !== 2'b01) begin
            n_err++;
            $display("FAIL set_beats_clear: got err=%b, want 01", err);
        end
        wait_lock(cnt);
        n_vec++;
        if (cnt != LOCK_CYCLES - 1 || mult !== 8'd3 || div !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_lock: got cnt=%0d mult=%0d div=%0d, want %0d 3 0", cnt, mult, div, LOCK_CYCLES - 1);
        end
        pulse_err_clear();
        // one past the limit: rejected
        send_load(SEL_M, 8'h04);
        do_go("m_over_limit");
        pulse_err_clear();
    endtask

    task automatic test_reset_midframe();
        int cnt;
        logic [15:0] bits;
        send_load(SEL_D, 8'h01);
        send_load(SEL_M, 8'h05);
        do_go("pre_reset");
        bits = 16'({8'h07, SEL_M, OP_LOAD});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pif.prog_en = 1'b1;
            pif.prog_data = bits[i];
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (mult !== 8'd3 || div !== 8'd0 || pif.prog_done !== 1'b0 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got mult=%0d div=%0d done=%b locked=%b, want 3 0 0 0",
                     mult, div, pif.prog_done, locked);
        end
        @(negedge clk);
        pif.prog_en = 1'b0;
        pif.prog_data = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wait_lock(cnt);
        n_vec++;
        if (cnt != LOCK_CYCLES) begin
            n_err++;
            $display("FAIL midframe_lock_time: got %0d cycles, want %0d", cnt, LOCK_CYCLES);
        end
        do_go("post_reset");
        n_vec++;
        if (mult !== 8'd3 || err !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_mult: got mult=%0d err=%b, want 3 00", mult, err);
        end
    endtask

    initial begin
        pif.prog_en = 1'b0;
        pif.prog_data = 1'b0;
        test_reset();
        test_load_go();
        test_framing();
        test_invalid();
        test_back_to_back();
        test_reset_midframe();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d unmatched, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
